// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding, the
// NOP fill word and the fetch address check.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000013;

    // A fetch is rejected if it is not word aligned or falls past the array.
    function automatic logic fetch_err(input logic [31:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port, one write port, read-before-write
// on a same-cycle collision. Filled with FILL at time zero only.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] FILL        = 32'h00000013
) (
    input  logic                           clk,
    input  logic                           rd_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [31:0]                    rd_data,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [31:0]                    wr_data
);

    logic [31:0] mem [DEPTH_WORDS] = '{default: FILL};

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Responder end of the instruction-fetch interface: serves word fetches from a
// local array after LATENCY wait cycles, with flush and a program-load port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [15:0] drop_count
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(LATENCY - 1);

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic [31:0] fetch_addr_q;
    logic        data_ok_q;

    logic        accept;
    logic        req_err;
    logic        rd_en;
    logic        wr_ok;
    logic [31:0] ram_data;
    logic        unused_wr_lsb;

    assign req_ready = !reset && !flush &&
                       (state_q == StIdle || (state_q == StResp && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign req_err   = fetch_err(req_addr, DEPTH_WORDS);

    // Gated by flush so a killed fetch cannot disturb the held response data.
    assign rd_en = (state_q == StWait) && (wait_cnt_q == 4'd0) && !flush;
    assign wr_ok = wr_en && ({2'b00, wr_addr[31:2]} < DEPTH_WORDS);

    assign unused_wr_lsb = ^wr_addr[1:0];

    // The RAM output register only moves on a good read, so masking it is enough
    // to give 0 after reset and on error responses while holding otherwise.
    assign rsp_data = data_ok_q ? ram_data : 32'h0;

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .FILL        (NOP_WORD)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (fetch_addr_q[IDX_W+1:2]),
        .rd_data (ram_data),
        .wr_en   (wr_ok),
        .wr_idx  (wr_addr[IDX_W+1:2]),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wait_cnt_q   <= 4'd0;
            fetch_addr_q <= 32'h0;
            data_ok_q    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_addr     <= 32'h0;
            rsp_err      <= 1'b0;
            drop_count   <= 16'h0;
        end else if (flush) begin
            // A response taken in the flush cycle was delivered, not dropped.
            if (state_q == StWait || (state_q == StResp && !rsp_ready)) begin
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StWait: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_addr  <= fetch_addr_q;
                        rsp_err   <= 1'b0;
                        data_ok_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Accepts only happen in IDLE or on a RESP handshake; overrides the above.
            if (accept) begin
                if (req_err) begin
                    state_q   <= StResp;
                    rsp_valid <= 1'b1;
                    rsp_addr  <= req_addr;
                    rsp_err   <= 1'b1;
                    data_ok_q <= 1'b0;
                end else begin
                    state_q      <= StWait;
                    wait_cnt_q   <= WAIT_LOAD;
                    fetch_addr_q <= req_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] drop_count;

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .NOP_WORD    (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_addr   (rsp_addr),
        .rsp_err    (rsp_err),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: a memory image, an outstanding fetch with the edge index at which
    // its response is due, and the response currently offered.
    logic [31:0] mmem [DEPTH];
    bit          m_busy;
    int          m_due;
    logic [31:0] m_fetch;
    bit          m_rv;
    logic [31:0] m_data;
    logic [31:0] m_addr;
    bit          m_err;
    int          m_drops;
    int          ecount;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic bit exp_ready();
        return !reset && !flush && ((!m_busy && !m_rv) || (m_rv && rsp_ready));
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_rv    = 0;
        m_drops = 0;
    endtask

    task automatic model_edge();
        bit acc;
        acc = req_valid && exp_ready();
        if (flush) begin
            if (m_busy || (m_rv && !rsp_ready)) begin
                if (m_drops < 65535) m_drops++;
            end
            m_busy = 0;
            m_rv   = 0;
        end else begin
            if (m_rv && rsp_ready) m_rv = 0;
            if (m_busy && ecount == m_due) begin
                m_busy = 0;
                m_rv   = 1;
                m_data = mmem[m_fetch / 4];
                m_addr = m_fetch;
                m_err  = 0;
            end
            if (acc) begin
                if (is_err(req_addr)) begin
                    m_rv   = 1;
                    m_data = 32'h0;
                    m_addr = req_addr;
                    m_err  = 1;
                end else begin
                    m_busy  = 1;
                    m_due   = ecount + int'(LAT);
                    m_fetch = req_addr;
                end
            end
        end
        if (wr_en && (wr_addr / 4) < DEPTH) mmem[wr_addr / 4] = wr_data;
        ecount++;
    endtask

    task automatic compare();
        check("req_ready", 32'(req_ready), 32'(exp_ready()));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        if (m_rv) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_addr", rsp_addr, m_addr);
            check("rsp_err", 32'(rsp_err), 32'(m_err));
        end
    endtask

    task automatic step(input bit rv, input logic [31:0] ra, input bit rr, input bit fl,
                        input bit we, input logic [31:0] wa, input logic [31:0] wd);
        @(negedge clk);
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        flush     = fl;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        #1;
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input bit rr);
        step(0, 32'h0, rr, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic req(input logic [31:0] a, input bit rr);
        step(1, a, rr, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic quiet_inputs();
        req_valid = 0;
        req_addr  = 32'h0;
        rsp_ready = 0;
        flush     = 0;
        wr_en     = 0;
        wr_addr   = 32'h0;
        wr_data   = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mmem[i] = NOP;
        ecount = 0;
        m_due  = 0;
        m_fetch = 32'h0;
        m_data = 32'h0;
        m_addr = 32'h0;
        m_err  = 0;
        model_reset();
        quiet_inputs();
        reset = 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_rsp_addr", rsp_addr, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'h0);
        check("reset_drop", 32'(drop_count), 32'h0);
        @(negedge clk);
        reset = 0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'h1);

        // Preload and fetch word 0: valid two edges after the accept
        step(0, 32'h0, 1, 0, 1, 32'h0, 32'h00a00093);
        req(32'h0, 1);
        check("lat_e0_valid", 32'(rsp_valid), 32'h0);
        idle(1);
        check("lat_e1_valid", 32'(rsp_valid), 32'h0);
        idle(1);
        check("lat_e2_valid", 32'(rsp_valid), 32'h1);
        check("fetch0_data", rsp_data, 32'h00a00093);
        check("fetch0_addr", rsp_addr, 32'h0);
        check("fetch0_err", 32'(rsp_err), 32'h0);
        idle(1);

        // Error fetches respond one edge after the accept
        req(32'h6, 1);
        check("misalign_valid", 32'(rsp_valid), 32'h1);
        check("misalign_err", 32'(rsp_err), 32'h1);
        check("misalign_data", rsp_data, 32'h0);
        idle(1);
        req(32'h1000, 1);
        check("range_valid", 32'(rsp_valid), 32'h1);
        check("range_err", 32'(rsp_err), 32'h1);
        idle(1);

        // Backpressure: response held stable, then handshake plus new accept
        req(32'h4, 0);
        idle(0);
        idle(0);
        for (int i = 0; i < 5; i++) begin
            idle(0);
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_data", rsp_data, NOP);
            check("hold_addr", rsp_addr, 32'h4);
            check("hold_req_ready", 32'(req_ready), 32'h0);
        end
        req(32'h8, 1);
        check("b2b_gap", 32'(rsp_valid), 32'h0);
        idle(1);
        check("b2b_wait", 32'(rsp_valid), 32'h0);
        idle(1);
        check("b2b_valid", 32'(rsp_valid), 32'h1);
        check("b2b_addr", rsp_addr, 32'h8);
        idle(1);

        // Flush during WAIT kills the fetch; flush with handshake drops nothing
        req(32'hC, 1);
        step(0, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        check("flush_drop", 32'(drop_count), 32'h1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("flush_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req(32'h10, 0);
        idle(0);
        idle(0);
        check("resp_before_flush", 32'(rsp_valid), 32'h1);
        step(0, 32'h0, 1, 1, 0, 32'h0, 32'h0);
        check("flush_consumed_drop", 32'(drop_count), 32'h1);
        check("flush_consumed_valid", 32'(rsp_valid), 32'h0);

        // Write colliding with the read returns the old word
        req(32'hC, 1);
        idle(1);
        step(0, 32'h0, 1, 0, 1, 32'hC, 32'hDEADBEEF);
        check("collide_valid", 32'(rsp_valid), 32'h1);
        check("collide_old", rsp_data, 32'h00000013);
        idle(1);
        req(32'hC, 1);
        idle(1);
        idle(1);
        check("after_write", rsp_data, 32'hDEADBEEF);
        idle(1);

        // Asynchronous reset mid-WAIT; memory survives
        req(32'h18, 1);
        quiet_inputs();
        #2;
        reset = 1;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'h0);
        check("async_drop", 32'(drop_count), 32'h0);
        check("async_req_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        req(32'hC, 1);
        idle(1);
        idle(1);
        check("mem_kept", rsp_data, 32'hDEADBEEF);
        idle(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra;
            logic [31:0] wa;
            int unsigned sel;
            sel = $urandom_range(0, 15);
            if (sel == 0) ra = $urandom;
            else if (sel == 1) ra = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 2) ra = 32'($urandom_range(DEPTH - 2, DEPTH + 1)) * 4;
            else ra = 32'($urandom_range(0, 31)) * 4;
            if ($urandom_range(0, 7) == 0) wa = 32'($urandom_range(DEPTH, DEPTH + 8)) * 4;
            else wa = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            step(bit'($urandom_range(0, 1)), ra, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, wa, $urandom);
        end
        for (int i = 0; i < int'(LAT) + 2; i++) idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Responder end of the instruction-fetch interface. It serves word fetch requests from the fetch stage out of a local instruction memory, after a configurable number of wait states. Request and response both use valid/ready handshakes. It supports a pipeline flush that kills an in-flight fetch, and a program-load write port used by the bench and the boot loader.

Parameters:
DEPTH_WORDS, 1024, instruction memory depth in 32-bit words (power of two, >=16)
LATENCY, 2, wait cycles from request accept to response valid (1..15)
NOP_WORD, 32'h00000013, time-zero fill value for every memory word

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept request this cycle
req_addr  in  32  byte address of fetch
rsp_valid  out  1  response valid
rsp_ready  in  1  fetch stage accepts response
rsp_data  out  32  instruction word (0 when rsp_err)
rsp_addr  out  32  byte address the response belongs to
rsp_err  out  1  misaligned or out-of-range fetch
flush  in  1  kill in-flight fetch/response
wr_en  in  1  program-load write strobe
wr_addr  in  32  byte address of write (bits[1:0] ignored)
wr_data  in  32  write data
drop_count  out  16  saturating count of fetches killed by flush

Behaviour:
- Reset (async, active-high): state IDLE; req_ready=0 while reset is asserted, then 1 in IDLE; rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, drop_count=0, wait counter=0. Memory contents are not affected by reset. Memory is NOP_WORD-filled at time zero only.
- States: IDLE, WAIT, RESP.
- req_ready = !flush && (state==IDLE || (state==RESP && rsp_ready)).
- Accept happens at the edge where req_valid && req_ready. The block latches addr.
  - Error: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS. The block goes to RESP on the next edge with rsp_err=1 and rsp_data=0, so the response follows the accept by 1 cycle regardless of LATENCY.
  - Otherwise: counter loads LATENCY-1 and the block goes to WAIT.
- WAIT: the counter decrements each cycle. When the counter==0, the block reads mem[addr[31:2]] and goes to RESP on that edge with rsp_err=0. An accept at edge E0 gives rsp_valid high after edge E0+LATENCY.
- RESP: rsp_valid=1. rsp_data, rsp_addr and rsp_err are held stable until rsp_ready.
  - On handshake with no new accept: go to IDLE.
  - On handshake plus a simultaneous accept: go to WAIT (or to RESP for an error fetch). rsp_valid drops for at least one cycle on a WAIT path.
- Read/write collision: a write in the same cycle as the WAIT->RESP read returns the old word; the write lands afterwards.
- wr_en writes mem[wr_addr[31:2]] at the clock edge, independent of state. Out-of-range writes are dropped silently.
- flush has priority over everything.
  - In WAIT or RESP (with rsp_valid=1 and no handshake that cycle): next state IDLE, rsp_valid=0 next cycle, drop_count+1 (saturates at 16'hFFFF).
  - In RESP with rsp_ready=1 in the flush cycle: the response counts as consumed, no drop is counted, and the state goes to IDLE.
  - In IDLE: no effect except req_ready=0.
- Reset asserted mid-WAIT/RESP: immediate return to IDLE with all outputs at reset values. drop_count is cleared.
- rsp_data, rsp_addr and rsp_err keep their last values in IDLE/WAIT. They are valid only when rsp_valid=1.

Decomposition:
- Shared pipeline package: state encoding typedef (IDLE/WAIT/RESP), NOP_WORD constant, and the error-check function (misaligned/out-of-range).
- One natural sub-module: imem_array (single-port-read, single-port-write synchronous RAM with time-zero fill) so the array can be swapped for an SRAM macro.

Test Plan:
- Reset, then preload mem[0]=32'h00a00093 via wr_en; req addr 0x0 with LATENCY=2, rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_data=32'h00a00093, rsp_addr=0, rsp_err=0.
- req addr 0x6 (misaligned) -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0; req addr 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1.
- rsp_ready held low 5 cycles after response for addr 0x4 -> rsp_valid/rsp_data stable all 5 cycles, req_ready=0; then rsp_ready=1 with req_valid, addr 0x8 -> accept same cycle, next response addr 0x8 after LATENCY.
- flush 1 cycle after accepting addr 0xC -> no rsp_valid ever for 0xC, state IDLE, drop_count=1; flush in RESP with rsp_ready=1 -> drop_count unchanged.
- Write mem[3]=32'hDEADBEEF in the same cycle the WAIT->RESP read of addr 0xC occurs -> rsp_data=old value 32'h00000013; the next fetch of 0xC returns 32'hDEADBEEF.
- Assert reset asynchronously mid-WAIT -> rsp_valid=0 and drop_count=0 immediately; after release, a fetch of a previously written address returns the written data (memory preserved).
